// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer: RV32M sequencer with shift-add multiplier and restoring divider
// Define FAST_MUL_EN for a single-cycle combinational multiplier; dividers are always iterative.
module ex_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             stall_o
);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state;
  logic [2:0] f3;
  logic [4:0] cnt;
  logic [63:0] acc, mcand, sum, prod;
  logic [31:0] mplier, quo, rem, dvs, res, held;
  logic [31:0] ma, mb, spec_res, mul_res, div_res, qf, rf;
  logic [32:0] trial;
  logic neg, neg_r, sa, sb, zero, ovf;
`ifdef FAST_MUL_EN
  logic [32:0] fa, fb;
  logic [63:0] fp;
  logic [31:0] fast_res;
`endif
  always_comb begin
    sa = funct3_i[2] ? ~funct3_i[0] & a_i[31] : (funct3_i[1:0] != 2'b11) & a_i[31];
    sb = funct3_i[2] ? ~funct3_i[0] & b_i[31] : ~funct3_i[1] & b_i[31];
    ma = sa ? -a_i : a_i;
    mb = sb ? -b_i : b_i;
    zero = b_i == 32'd0;
    ovf = ~funct3_i[0] & (a_i == 32'h8000_0000) & (b_i == 32'hFFFF_FFFF);
    spec_res = zero ? (funct3_i[1] ? a_i : 32'hFFFF_FFFF) : (funct3_i[1] ? 32'd0 : 32'h8000_0000);
    sum = acc + (mplier[0] ? mcand : 64'd0);
    prod = neg ? -sum : sum;
    mul_res = f3 == 3'd0 ? prod[31:0] : prod[63:32];
    trial = {rem, quo[31]} - {1'b0, dvs};
    qf = neg ? -quo : quo;
    rf = neg_r ? -rem : rem;
    div_res = f3[1] ? rf : qf;
`ifdef FAST_MUL_EN
    fa = {(funct3_i[1:0] != 2'b11) & a_i[31], a_i};
    fb = {~funct3_i[1] & b_i[31], b_i};
    fp = 64'($signed(fa)) * 64'($signed(fb));
    fast_res = funct3_i == 3'd0 ? fp[31:0] : fp[63:32];
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 5'd0;
      res <= 32'd0;
      held <= 32'd0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          f3 <= funct3_i;
          neg <= sa ^ sb;
          neg_r <= sa;
          cnt <= 5'd0;
          acc <= 64'd0;
          mcand <= {32'd0, ma};
          mplier <= mb;
          rem <= 32'd0;
          quo <= ma;
          dvs <= mb;
          if (funct3_i[2]) begin
            if (zero | ovf) begin
              res <= spec_res;
              state <= DONE;
            end else state <= DIV;
          end else begin
`ifdef FAST_MUL_EN
            res <= fast_res;
            state <= DONE;
`else
            state <= MUL;
`endif
          end
        end
        MUL: begin
          acc <= sum;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            res <= mul_res;
            state <= DONE;
          end
        end
        // a failed trial subtraction leaves the shifted remainder below the divisor, so bit 32 is zero
        DIV: begin
          rem <= trial[32] ? {rem[30:0], quo[31]} : trial[31:0];
          quo <= {quo[30:0], ~trial[32]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          res <= div_res;
          state <= DONE;
        end
        DONE: begin
          held <= res;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign busy_o = (state == MUL) | (state == DIV) | (state == FIX);
  assign done_o = (state == DONE) & ~flush_i;
  assign result_o = done_o ? res : held;
  assign stall_o = start_i & ~done_o & ~flush_i;
endmodule
